// File: rtl/dbus_sink_pkg.sv
// Shared definitions for the data-bus sink: widths, source-enable bit map, write FSM states.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package dbus_sink_pkg;

    // Default bus/register width and default write wait-state budget.
    localparam int DW_DEF  = 16;
    localparam int TMO_DEF = 15;

    // Wait counter is wide enough for the largest legal TMO (255).
    localparam int CNT_W = 8;

    // Bit positions inside src_en, mirrored from the bus source multiplexer.
    localparam int SRC_ALU  = 0;
    localparam int SRC_B    = 1;
    localparam int SRC_DMEM = 2;
    localparam int SRC_IR   = 3;
    localparam int SRC_N    = 4;

    // Memory write port states.
    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_WAIT = 1'b1
    } wr_state_t;

    // True when exactly one bus source is driving.
    function automatic logic src_onehot(input logic [SRC_N-1:0] en);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < SRC_N; i++) begin
            cnt += 32'(en[i]);
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/dbus_wr_port.sv
// Data-memory write port: latches one address/data pair and holds it on a valid/ready request.
// Latency: request visible the cycle after the strobe; busy drops the cycle after ready or timeout.
// Backpressure: busy stays high while waiting for ready; abandons the write after TMO+1 wait cycles.
module dbus_wr_port
    import dbus_sink_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic          busy,
    output logic          mem_valid,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic          mem_ready,
    output logic          tmo
);

    // TMO is documented as 1..255, so it always fits the counter width.
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TMO);

    wr_state_t        state;
    logic [CNT_W-1:0] wait_cnt;

    // Write FSM: capture on request in IDLE, hold until ready or the wait budget runs out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WR_IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            wait_cnt  <= '0;
            tmo       <= 1'b0;
        end else begin
            unique case (state)
                WR_IDLE: begin
                    // Ready is deliberately not looked at here; only a held request counts.
                    if (req) begin
                        mem_addr  <= addr;
                        mem_data  <= data;
                        mem_valid <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    // Ready wins over timeout when both happen on the last wait cycle.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= WR_IDLE;
                    end else if (wait_cnt == TMO_CNT) begin
                        tmo       <= 1'b1;
                        mem_valid <= 1'b0;
                        state     <= WR_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    state     <= WR_IDLE;
                end
            endcase
        end
    end

    // The sequencer must hold for every cycle spent waiting on memory.
    assign busy = (state == WR_WAIT);

endmodule

// File: rtl/dbus_sink.sv
// Data-bus destination: loads A/B/DR from DBUS_in and forwards bus writes to data memory.
// Latency: register loads visible 1 cycle after the strobe; memory request issued 1 cycle after mem_wr.
// Backpressure: stall is high while a write waits for dmem_wr_ready; strobes are ignored while stalled.
module dbus_sink
    import dbus_sink_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    DBUS_in,
    input  logic [SRC_N-1:0] src_en,
    input  logic             A_load,
    input  logic             B_load,
    input  logic             DR_load,
    input  logic             mem_wr,
    output logic [DW-1:0]    A_out,
    output logic [DW-1:0]    B_out,
    output logic [DW-1:0]    DR_out,
    output logic             dmem_wr_valid,
    output logic [DW-1:0]    dmem_wr_addr,
    output logic [DW-1:0]    dmem_wr_data,
    input  logic             dmem_wr_ready,
    output logic             stall,
    output logic             bus_err,
    output logic             wr_tmo
);

    // A bus strobe only takes effect when the sequencer is not held.
    logic bus_use;
    logic src_bad;

    assign bus_use = (A_load | B_load | DR_load | mem_wr) & ~stall;
    assign src_bad = ~src_onehot(src_en);

    // Datapath registers: every asserted load captures the same bus value.
    always_ff @(posedge clk) begin
        if (rst) begin
            A_out  <= '0;
            B_out  <= '0;
            DR_out <= '0;
        end else if (!stall) begin
            if (A_load) begin
                A_out <= DBUS_in;
            end
            if (B_load) begin
                B_out <= DBUS_in;
            end
            if (DR_load) begin
                DR_out <= DBUS_in;
            end
        end
    end

    // Sticky bus-usage error: a consumer sampled the bus with zero or several drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (bus_use && src_bad) begin
            bus_err <= 1'b1;
        end
    end

    // The address is the registered A, so a same-cycle A_load cannot alter it.
    dbus_wr_port #(
        .DW  (DW),
        .TMO (TMO)
    ) u_wr (
        .clk       (clk),
        .rst       (rst),
        .req       (mem_wr),
        .addr      (A_out),
        .data      (DBUS_in),
        .busy      (stall),
        .mem_valid (dmem_wr_valid),
        .mem_addr  (dmem_wr_addr),
        .mem_data  (dmem_wr_data),
        .mem_ready (dmem_wr_ready),
        .tmo       (wr_tmo)
    );

endmodule

// File: tb/tb_dbus_sink.sv
// Bench for dbus_sink: directed vectors, memory writes checked by a scoreboard monitor.
// Latency: n/a.
// Backpressure: drives dmem_wr_ready low/high to exercise wait states and timeout.
module tb_dbus_sink;

    logic        clk;
    logic        rst;
    logic [15:0] dbus;
    logic [3:0]  src_en;
    logic        a_load;
    logic        b_load;
    logic        dr_load;
    logic        mem_wr;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic [15:0] dr_out;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        stall;
    logic        bus_err;
    logic        wr_tmo;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    wr_exp_t mon_e;

    dbus_sink dut (
        .clk           (clk),
        .rst           (rst),
        .DBUS_in       (dbus),
        .src_en        (src_en),
        .A_load        (a_load),
        .B_load        (b_load),
        .DR_load       (dr_load),
        .mem_wr        (mem_wr),
        .A_out         (a_out),
        .B_out         (b_out),
        .DR_out        (dr_out),
        .dmem_wr_valid (wr_valid),
        .dmem_wr_addr  (wr_addr),
        .dmem_wr_data  (wr_data),
        .dmem_wr_ready (wr_ready),
        .stall         (stall),
        .bus_err       (bus_err),
        .wr_tmo        (wr_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dbus     = '0;
        src_en   = '0;
        a_load   = 1'b0;
        b_load   = 1'b0;
        dr_load  = 1'b0;
        mem_wr   = 1'b0;
        wr_ready = 1'b0;
    endtask

    task automatic rand_inputs();
        dbus     = 16'($urandom);
        src_en   = 4'($urandom);
        a_load   = 1'($urandom);
        b_load   = 1'($urandom);
        dr_load  = 1'($urandom);
        mem_wr   = 1'($urandom);
        wr_ready = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every accepted memory write must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset with random inputs for two cycles.
        rst = 1'b1;
        rand_inputs();
        tick();
        rand_inputs();
        tick();
        rst = 1'b0;
        clear_inputs();
        check("rst_a", 32'(a_out), 32'h0);
        check("rst_b", 32'(b_out), 32'h0);
        check("rst_dr", 32'(dr_out), 32'h0);
        check("rst_valid", 32'(wr_valid), 32'h0);
        check("rst_addr_data", {wr_addr, wr_data}, 32'h0);
        check("rst_flags", {29'h0, stall, bus_err, wr_tmo}, 32'h0);

        // Idle bus with bad src_en but no strobe must not flag an error.
        src_en = 4'b1111;
        tick();
        src_en = 4'b0000;
        tick();
        check("no_strobe_no_err", 32'(bus_err), 32'h0);

        // Single A load.
        src_en = 4'b0001;
        dbus   = 16'h1234;
        a_load = 1'b1;
        tick();
        clear_inputs();
        check("load_a", 32'(a_out), 32'h1234);
        check("load_b_untouched", 32'(b_out), 32'h0);
        check("load_dr_untouched", 32'(dr_out), 32'h0);
        check("load_no_err", 32'(bus_err), 32'h0);

        // Write with three wait states; B_load during stall is ignored.
        src_en = 4'b0001;
        dbus   = 16'h0040;
        a_load = 1'b1;
        tick();
        clear_inputs();
        src_en = 4'b0010;
        dbus   = 16'hBEEF;
        mem_wr = 1'b1;
        exp_q.push_back('{addr: 16'h0040, data: 16'hBEEF});
        tick();
        mem_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wait_valid_%0d", i), 32'(wr_valid), 32'h1);
            check($sformatf("wait_stall_%0d", i), 32'(stall), 32'h1);
            check($sformatf("wait_hold_%0d", i), {wr_addr, wr_data}, 32'h0040BEEF);
            if (i == 1) begin
                b_load = 1'b1;
                dbus   = 16'h5555;
            end
            if (i == 2) begin
                b_load = 1'b0;
            end
            if (i == 3) begin
                wr_ready = 1'b1;
            end
            tick();
        end
        wr_ready = 1'b0;
        check("wait_done_valid", 32'(wr_valid), 32'h0);
        check("wait_done_stall", 32'(stall), 32'h0);
        check("stall_load_ignored", 32'(b_out), 32'h0);

        // Back-to-back writes with mem_wr held and ready immediate.
        src_en   = 4'b0010;
        dbus     = 16'h1111;
        mem_wr   = 1'b1;
        wr_ready = 1'b1;
        exp_q.push_back('{addr: 16'h0040, data: 16'h1111});
        exp_q.push_back('{addr: 16'h0040, data: 16'h2222});
        tick();
        check("b2b_first_valid", 32'(wr_valid), 32'h1);
        dbus = 16'h2222;
        tick();
        check("b2b_gap_valid", 32'(wr_valid), 32'h0);
        check("b2b_gap_stall", 32'(stall), 32'h0);
        tick();
        check("b2b_second_valid", 32'(wr_valid), 32'h1);
        mem_wr = 1'b0;
        tick();
        check("b2b_done_valid", 32'(wr_valid), 32'h0);
        clear_inputs();

        // Timeout: ready never comes; valid lasts TMO+1 = 16 cycles.
        src_en = 4'b0100;
        dbus   = 16'hCAFE;
        mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
        check("tmo_before", 32'(wr_tmo), 32'h0);
        n = 0;
        while (wr_valid && n < 40) begin
            n++;
            tick();
        end
        check("tmo_valid_cycles", 32'(n), 32'd16);
        check("tmo_flag", 32'(wr_tmo), 32'h1);
        check("tmo_idle", {30'h0, wr_valid, stall}, 32'h0);
        tick();
        tick();
        tick();
        check("tmo_sticky", 32'(wr_tmo), 32'h1);

        // Bus error: DR load with no source driving.
        do_reset();
        src_en  = 4'b0001;
        dbus    = 16'hABCD;
        dr_load = 1'b1;
        tick();
        check("dr_prep", 32'(dr_out), 32'hABCD);
        check("dr_prep_no_err", 32'(bus_err), 32'h0);
        src_en = 4'b0000;
        dbus   = 16'h0000;
        tick();
        clear_inputs();
        check("err_zero_dr", 32'(dr_out), 32'h0);
        check("err_zero_flag", 32'(bus_err), 32'h1);
        tick();
        tick();
        check("err_sticky", 32'(bus_err), 32'h1);

        // Bus error: A load with two sources driving.
        do_reset();
        check("err_cleared_by_rst", 32'(bus_err), 32'h0);
        src_en = 4'b0101;
        dbus   = 16'h5A5A;
        a_load = 1'b1;
        tick();
        clear_inputs();
        check("err_multi_flag", 32'(bus_err), 32'h1);
        check("err_multi_a", 32'(a_out), 32'h5A5A);

        // Reset in the middle of a wait.
        do_reset();
        src_en = 4'b0001;
        dbus   = 16'h7777;
        mem_wr = 1'b1;
        tick();
        mem_wr = 1'b0;
        tick();
        check("midrst_waiting", 32'(wr_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(wr_valid), 32'h0);
        check("midrst_stall", 32'(stall), 32'h0);
        check("midrst_tmo", 32'(wr_tmo), 32'h0);
        wr_ready = 1'b1;
        tick();
        tick();
        wr_ready = 1'b0;
        check("midrst_stays_idle", 32'(wr_valid), 32'h0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
